fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: 6502 instruction fetch from a 3-byte-wide program memory, with
// length decode, valid/ready output register and PC redirect. Define FETCH_STATS_EN for counters.
package fetch_pkg;
  localparam int MEM_ADDR_SIZE = 16;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W            = MEM_ADDR_SIZE,
  parameter logic [ADDR_W-1:0] RESET_VECTOR_ADDR = ADDR_W'(16'hFFFC)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [23:0]       mem_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [7:0]        out_opcode_o,
  output logic [15:0]       out_operand_o,
  output logic [1:0]        out_len_o,
  output logic [ADDR_W-1:0] out_pc_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count_o,
  output logic [31:0]       stall_count_o
`endif
);

  typedef enum logic {VECTOR, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        len;
  logic [15:0]       operand;
  logic              load;

  // 6502 instruction length from the opcode's aaa/bbb/cc fields.
  function automatic logic [1:0] len_of(input logic [7:0] o);
    logic [2:0] a, b;
    logic [1:0] c;
    a = o[7:5];
    b = o[4:2];
    c = o[1:0];
    if (b == 3'd3 || b == 3'd7 || (b == 3'd6 && c[0]) || o == 8'h20)
      return 2'd3;
    else if ((b == 3'd2 && !c[0]) || (b == 3'd6 && !c[0]) ||
             (b == 3'd0 && c == 2'd0 && (a == 3'd2 || a == 3'd3)))
      return 2'd1;
    else
      return 2'd2;
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    len     = len_of(mem_data_i[7:0]);
    operand = 16'h0000;
    case (len)
      2'd2:    operand = {8'h00, mem_data_i[15:8]};
      2'd3:    operand = mem_data_i[23:8];
      default: operand = 16'h0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= VECTOR;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      VECTOR:  state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = VECTOR;
    endcase
  end

  always_comb begin
    mem_addr_o = pc;
    if (state == VECTOR) mem_addr_o = RESET_VECTOR_ADDR;
  end

  // Redirect takes precedence over loading a new instruction.
  assign load = (state == RUN) && !redirect_i && (!out_valid_o || out_ready_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pc            <= '0;
      out_valid_o   <= 1'b0;
      out_opcode_o  <= 8'h00;
      out_operand_o <= 16'h0000;
      out_len_o     <= 2'd1;
      out_pc_o      <= '0;
    end else if (state == VECTOR) begin
      pc <= ADDR_W'(mem_data_i[15:0]);
    end else if (redirect_i) begin
      pc          <= redirect_pc_i;
      out_valid_o <= 1'b0;
    end else if (load) begin
      out_opcode_o  <= mem_data_i[7:0];
      out_operand_o <= operand;
      out_len_o     <= len;
      out_pc_o      <= pc;
      out_valid_o   <= 1'b1;
      pc            <= pc + ADDR_W'(len);
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_count_o <= '0;
      stall_count_o <= '0;
    end else if (state == RUN) begin
      if (out_valid_o && out_ready_i)  fetch_count_o <= fetch_count_o + 32'd1;
      if (out_valid_o && !out_ready_i) stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reset vector, stream, backpressure,
// redirects, address wrap, full opcode-length sweep and reset mid-handshake.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] mem_addr;
  logic [23:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [15:0] out_operand;
  logic [1:0]  out_len;
  logic [15:0] out_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [7:0] mem [0:65535];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_opcode_o  (out_opcode),
    .out_operand_o (out_operand),
    .out_len_o     (out_len),
    .out_pc_o      (out_pc)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count_o (fetch_count),
    .stall_count_o (stall_count)
`endif
  );

  // Program memory: 3-byte window, address arithmetic wraps at 16 bits.
  logic [15:0] a1, a2;
  assign a1 = mem_addr + 16'd1;
  assign a2 = mem_addr + 16'd2;
  assign mem_data = {mem[a2], mem[a1], mem[mem_addr]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference length table written as opcode bit patterns.
  function automatic logic [1:0] golden_len(input logic [7:0] o);
    if (o == 8'h20) return 2'd3;
    casez (o)
      8'b???011??, 8'b???111??, 8'b???110?1: return 2'd3;
      8'b???010?0, 8'b???110?0, 8'h40, 8'h60: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  typedef struct {
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        pay;      // compare the instruction payload on this row
    logic        valid;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic [15:0] pc;
    logic [15:0] addr;
  } row_t;

  row_t rows [16];

  initial begin
    rows[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h8D, 16'h0200, 2'd3, 16'h8002, 16'h8005};
    rows[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h8D, 16'h0200, 2'd3, 16'h8002, 16'h8005};
    rows[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h8D, 16'h0200, 2'd3, 16'h8002, 16'h8005};
    rows[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h8D, 16'h0200, 2'd3, 16'h8002, 16'h8005};
    rows[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hE8, 16'h0000, 2'd1, 16'h8005, 16'h8006};
    rows[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h20, 16'h1234, 2'd3, 16'h8006, 16'h8009};
    rows[6]  = '{1'b1, 1'b1, 16'h8002, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000, 16'h8002};
    rows[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h8D, 16'h0200, 2'd3, 16'h8002, 16'h8005};
    rows[8]  = '{1'b1, 1'b1, 16'hC000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000, 16'hC000};
    rows[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hBD, 16'h1234, 2'd3, 16'hC000, 16'hC003};
    rows[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hEA, 16'h0000, 2'd1, 16'hC003, 16'hC004};
    rows[11] = '{1'b0, 1'b1, 16'h9000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000, 16'h9000};
    rows[12] = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000, 16'hFFFE};
    rows[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hEA, 16'h0000, 2'd1, 16'hFFFE, 16'hFFFF};
    rows[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h4C, 16'h9000, 2'd3, 16'hFFFF, 16'h0002};
    rows[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h4C, 16'h9000, 2'd3, 16'hFFFF, 16'h0002};

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'hFFFE] = 8'hEA; mem[16'hFFFF] = 8'h4C;
    mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h90;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h05; mem[16'h8002] = 8'h8D;
    mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02; mem[16'h8005] = 8'hE8;
    mem[16'h8006] = 8'h20; mem[16'h8007] = 8'h34; mem[16'h8008] = 8'h12;
    mem[16'hC000] = 8'hBD; mem[16'hC001] = 8'h34; mem[16'hC002] = 8'h12;

    rstn = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    step(); step();
    check("reset_valid",   64'(out_valid),   64'(0));
    check("reset_opcode",  64'(out_opcode),  64'(0));
    check("reset_operand", 64'(out_operand), 64'(0));
    check("reset_len",     64'(out_len),     64'(1));
    check("reset_pc",      64'(out_pc),      64'(0));
    check("vector_addr",   64'(mem_addr),    64'(16'hFFFC));
`ifdef FETCH_STATS_EN
    check("reset_fetch_count", 64'(fetch_count), 64'(0));
    check("reset_stall_count", 64'(stall_count), 64'(0));
`endif

    rstn = 1'b1;
    step();
    check("cycle1_valid", 64'(out_valid), 64'(0));
    check("cycle1_addr",  64'(mem_addr),  64'(16'h8000));
    step();
    check("first_instr", {out_valid, out_opcode, out_operand, out_len, out_pc, mem_addr},
          {1'b1, 8'hA9, 16'h0005, 2'd2, 16'h8000, 16'h8002});

    for (int i = 0; i < 16; i++) begin
      out_ready = rows[i].ready; redirect = rows[i].redir; redirect_pc = rows[i].rpc;
      step();
      check($sformatf("row%0d_valid", i), 64'(out_valid), 64'(rows[i].valid));
      check($sformatf("row%0d_addr", i),  64'(mem_addr),  64'(rows[i].addr));
      if (rows[i].pay)
        check($sformatf("row%0d_payload", i), {out_opcode, out_operand, out_len, out_pc},
              {rows[i].opcode, rows[i].operand, rows[i].len, rows[i].pc});
    end
    redirect = 1'b0;
`ifdef FETCH_STATS_EN
    check("stall_count", 64'(stall_count), 64'(5));
`endif

    // Length sweep: redirect to a scratch slot holding each opcode in turn.
    for (int op = 0; op < 256; op++) begin
      logic [7:0]  o;
      logic [1:0]  l;
      logic [15:0] exp_operand;
      o = 8'(op);
      l = golden_len(o);
      exp_operand = (l == 2'd1) ? 16'h0000 : (l == 2'd2) ? 16'h0011 : 16'h2211;
      mem[16'h2000] = o; mem[16'h2001] = 8'h11; mem[16'h2002] = 8'h22;
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h2000;
      step();
      redirect = 1'b0;
      step();
      check($sformatf("sweep_%02h", o), {out_valid, out_opcode, out_operand, out_len, out_pc, mem_addr},
            {1'b1, o, exp_operand, l, 16'h2000, 16'h2000 + 16'(l)});
    end

    // Reset while a handshake is in progress drops the instruction.
    out_ready = 1'b1; rstn = 1'b0;
    step();
    check("midreset", {out_valid, out_opcode, out_operand, out_len, out_pc, mem_addr},
          {1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000, 16'hFFFC});
`ifdef FETCH_STATS_EN
    check("midreset_counts", {fetch_count, stall_count}, 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
